// File: rtl/add_sub_serial_if.sv
`default_nettype none
// ============================================================================
// Module      : add_sub_serial_if
// Description : Handshake and data bundle for add_sub_serial.
//               master : requester (drives start/a/b/en, reads results)
//               slave  : the serial adder/subtractor itself
//               Signals: start, a, b, en, busy, done, sdout, cbout and
//               ovf (only when ADD_SUB_SERIAL_OVF_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
interface add_sub_serial_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             en;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sdout;
    logic             cbout;
`ifdef ADD_SUB_SERIAL_OVF_EN
    logic             ovf;

    modport master (output start, a, b, en,
                    input  busy, done, sdout, cbout, ovf);
    modport slave  (input  start, a, b, en,
                    output busy, done, sdout, cbout, ovf);
`else
    modport master (output start, a, b, en,
                    input  busy, done, sdout, cbout);
    modport slave  (input  start, a, b, en,
                    output busy, done, sdout, cbout);
`endif
endinterface
`default_nettype wire

// File: rtl/add_sub_serial.sv
`default_nettype none
// ============================================================================
// Module      : add_sub_serial
// Description : Digit-serial unsigned adder/subtractor. Processes DIGIT bits
//               per clock, LSB first, behind a start/busy/done handshake.
//               Result and carry/borrow are registered and held until the
//               next completion.
// Ports       : clk  - clock (rising edge)
//               rst  - synchronous active-high reset
//               bus  - add_sub_serial_if.slave
//                      start/a/b/en in; busy/done/sdout/cbout out
//                      (+ ovf out when ADD_SUB_SERIAL_OVF_EN is defined)
// Config      : ADD_SUB_SERIAL_OVF_EN - adds signed overflow output ovf
// Revision    : 1.0 - initial release
// ============================================================================
module add_sub_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  wire logic           clk,
    input  wire logic           rst,
    add_sub_serial_if.slave     bus
);

    localparam int c_N  = WIDTH / DIGIT;
    localparam int c_CW = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_N - 1);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [c_CW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] w_res_next;
    logic [WIDTH-1:0] r_sdout;
    logic             r_en;
    logic             r_carry;
    logic             r_cbout;
    logic             w_accept;
    logic             w_busy;
    logic             w_done;
    logic             w_last;
    logic [DIGIT-1:0] w_bslice;
    logic [DIGIT:0]   w_sum;
    logic             w_cout;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = c_IDLE;
        case (r_state)
            c_IDLE:  w_state_next = bus.start ? c_RUN : c_IDLE;
            c_RUN:   w_state_next = w_last ? c_DONE : c_RUN;
            c_DONE:  w_state_next = bus.start ? c_RUN : c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_busy   = (r_state == c_RUN);
        w_done   = (r_state == c_DONE);
        w_accept = bus.start && ((r_state == c_IDLE) || (r_state == c_DONE));
    end

    assign w_last = (r_cnt == c_LAST);

    // ------------------------------------------------------------------
    // One ripple slice: subtraction is a + ~b + 1, the +1 coming from the
    // carry flop being preloaded with en.
    // ------------------------------------------------------------------
    assign w_bslice = r_b[DIGIT-1:0] ^ {DIGIT{r_en}};
    assign w_sum    = {1'b0, r_a[DIGIT-1:0]} + {1'b0, w_bslice}
                    + {{DIGIT{1'b0}}, r_carry};
    assign w_cout   = w_sum[DIGIT];

    // Slice results enter from the MSB side so the first (lowest) digit
    // ends up at the bottom after N shifts.
    generate
        if (DIGIT == WIDTH) begin : g_single_digit
            assign w_res_next = w_sum[DIGIT-1:0];
        end else begin : g_multi_digit
            assign w_res_next = {w_sum[DIGIT-1:0], r_res[WIDTH-1:DIGIT]};
        end
    endgenerate

`ifdef ADD_SUB_SERIAL_OVF_EN
    logic w_cin_top;
    logic r_ovf;

    // Carry into the top bit of the slice, recovered from its sum bit.
    assign w_cin_top = w_sum[DIGIT-1] ^ r_a[DIGIT-1] ^ w_bslice[DIGIT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_busy && w_last) begin
            r_ovf <= w_cin_top ^ w_cout;
        end
    end

    assign bus.ovf = r_ovf;
`endif

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_en    <= 1'b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sdout <= '0;
            r_cbout <= 1'b0;
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_en    <= bus.en;
            r_carry <= bus.en;
            r_res   <= '0;
            r_cnt   <= '0;
        end else if (w_busy) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_res   <= w_res_next;
            r_carry <= w_cout;
            r_cnt   <= w_last ? '0 : r_cnt + c_ONE;
            if (w_last) begin
                r_sdout <= w_res_next;
                // Final carry of a + ~b + 1 is the inverse of the borrow.
                r_cbout <= w_cout ^ r_en;
            end
        end
    end

    assign bus.busy  = w_busy;
    assign bus.done  = w_done;
    assign bus.sdout = r_sdout;
    assign bus.cbout = r_cbout;

endmodule
`default_nettype wire
